// File: rtl/scan_pkg.sv
// Shared constants, FSM state codes and the leading-zero visibility helper
// for the digit scan controller.
package scan_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int SEL_W      = 2;
  localparam int NIBBLE_W   = 4;
  localparam int DATA_W     = NUM_DIGITS * NIBBLE_W;

  localparam logic [0:0] BLANK = 1'b0;
  localparam logic [0:0] ON    = 1'b1;

  // A digit is visible if it is digit 0 or if it or any more-significant nibble is non-zero.
  function automatic logic digit_visible(input logic [DATA_W-1:0] value,
                                         input logic [SEL_W-1:0]  idx);
    logic any_nz;
    any_nz = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k >= int'(idx) && value[k*NIBBLE_W +: NIBBLE_W] != '0) any_nz = 1'b1;
    end
    return (idx == '0) || any_nz;
  endfunction

endpackage

// File: rtl/digit_scan_ctrl_if.sv
// Load/display bus between the scan controller and its host / decoder.
interface digit_scan_ctrl_if;
  import scan_pkg::*;

  logic                load;
  logic [DATA_W-1:0]   digits_in;
  logic [SEL_W-1:0]    sel;
  logic                enable_n;
  logic [NIBBLE_W-1:0] digit_bcd;
  logic                frame_done;

  modport master (
    output load, digits_in,
    input  sel, enable_n, digit_bcd, frame_done
  );

  modport slave (
    input  load, digits_in,
    output sel, enable_n, digit_bcd, frame_done
  );
endinterface

// File: rtl/scan_timer.sv
// Phase counter for the scan FSM: counts up from 0 and flags the last cycle
// of the current phase (BLANK or ON length).
module scan_timer #(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic phase_on,
  output logic tc
);
  localparam int MAX_LEN = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(MAX_LEN);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] last;

  assign last = phase_on ? CNT_W'(DWELL_CYCLES - 1) : CNT_W'(BLANK_CYCLES - 1);
  assign tc   = (count == last);

  always_ff @(posedge clk) begin
    if (rst || tc) count <= '0;
    else           count <= count + CNT_W'(1);
  end
endmodule

// File: rtl/digit_scan_ctrl.sv
// Four-digit multiplexed display scan controller with frame-synchronous updates.
// Optional build macro: LEADING_ZERO_BLANK_EN keeps leading-zero digits dark.
module digit_scan_ctrl
  import scan_pkg::*;
#(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 4
) (
  input logic              clk,
  input logic              rst,
  digit_scan_ctrl_if.slave bus
);
  logic [0:0]          state;
  logic [0:0]          nxt_state;
  logic                phase_on;
  logic                tc;
  logic                advance;
  logic                boundary;
  logic                lit;
  logic [SEL_W-1:0]    sel_q;
  logic [SEL_W-1:0]    nxt_sel;
  logic [DATA_W-1:0]   shadow;
  logic [DATA_W-1:0]   active;
  logic [DATA_W-1:0]   nxt_active;
  logic                pending;
  logic [NIBBLE_W-1:0] bcd_q;
  logic                enable_n_q;
  logic                frame_done_q;

  assign phase_on = (state == ON);

  scan_timer #(
    .DWELL_CYCLES(DWELL_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .phase_on (phase_on),
    .tc       (tc)
  );

  // advance is high only in the first blank cycle after an ON phase, so the
  // digit right after reset keeps sel=0 and never counts as a frame boundary.
  assign nxt_state  = tc ? ~state : state;
  assign boundary   = advance && (sel_q == SEL_W'(NUM_DIGITS - 1));
  assign nxt_sel    = advance ? sel_q + SEL_W'(1) : sel_q;
  assign nxt_active = !boundary    ? active :
                      bus.load     ? bus.digits_in :
                      pending      ? shadow : active;

`ifdef LEADING_ZERO_BLANK_EN
  assign lit = digit_visible(active, sel_q);
`else
  assign lit = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= BLANK;
      advance      <= 1'b0;
      sel_q        <= '0;
      shadow       <= '0;
      active       <= '0;
      pending      <= 1'b0;
      bcd_q        <= '0;
      enable_n_q   <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state        <= nxt_state;
      advance      <= phase_on && tc;
      sel_q        <= nxt_sel;
      active       <= nxt_active;
      if (boundary) begin
        pending <= 1'b0;
      end else if (bus.load) begin
        shadow  <= bus.digits_in;
        pending <= 1'b1;
      end
      bcd_q        <= nxt_active[nxt_sel*NIBBLE_W +: NIBBLE_W];
      enable_n_q   <= !((nxt_state == ON) && lit);
      frame_done_q <= boundary;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.enable_n   = enable_n_q;
  assign bus.digit_bcd  = bcd_q;
  assign bus.frame_done = frame_done_q;
endmodule
